data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter num_bits, default 32: data word width.
REQ-002 SHALL have parameter addr_bits, default 6: word-index width; depth is 2**addr_bits words.
REQ-003 SHALL have parameter wait_cycles, default 2: wait states between request accept and response (0..15).
REQ-004 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port: req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port: req_addr  input  32  byte address.
REQ-010 SHALL have port: req_wdata  input  num_bits  store data.
REQ-011 SHALL have port: resp_valid  output  1  response presented.
REQ-012 SHALL have port: resp_ready  input  1  initiator accepts response.
REQ-013 SHALL have port: resp_rdata  output  num_bits  load data; 0 for stores and errors.
REQ-014 SHALL have port: resp_error  output  1  request rejected.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid && req_ready, registering write, addr, wdata.
REQ-017 SHALL, on accept, go to WAIT with wait counter loaded to wait_cycles-1, or directly to RESP when wait_cycles = 0.
REQ-018 SHALL decrement the counter each WAIT cycle and enter RESP on the edge where it reads 0.
REQ-019 SHALL assert resp_valid exactly 1+wait_cycles cycles after the accept edge; resp_valid, resp_rdata, resp_error held stable until resp_ready.
REQ-020 SHALL return to IDLE on the edge with resp_valid && resp_ready; no new request accepted on that edge (one idle cycle min between transactions).
REQ-021 SHALL flag error when any bit of req_addr[31:addr_bits+2] is 1 (out of range).
REQ-022 SHALL commit a non-error store to word req_addr[addr_bits+1:2] on the edge entering RESP; errored stores write nothing.
REQ-023 SHALL read load data from the memory word at the edge entering RESP; errored loads return resp_rdata = 0.
REQ-024 SHALL ignore req_write/req_addr/req_wdata changes after accept; req_valid outside IDLE has no effect.
REQ-025 SHALL make a load following a store to the same address return the stored value.

Reset
REQ-026 SHALL, with reset_n = 0 at an edge, force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_error 0; req_ready = 1 from the first edge after reset_n rises.
REQ-027 SHALL abort an in-flight transaction on reset: a store not yet committed SHALL NOT write; memory contents are not cleared by reset.

Configuration
REQ-028 SHALL, with macro DATA_MEM_ALIGN_CHECK_EN defined, additionally flag error when req_addr[1:0] != 0 (no write, rdata 0).
REQ-029 SHALL, without DATA_MEM_ALIGN_CHECK_EN, ignore req_addr[1:0] entirely and never flag misalignment.

Verification
REQ-030 SHALL cover: store 0xDEADBEEF to 0x10, then load 0x10 -> resp_rdata 0xDEADBEEF, resp_error 0.
REQ-031 SHALL cover: wait_cycles = 2, accept at edge N -> resp_valid first high after edge N+3; wait_cycles = 0 -> after edge N+1.
REQ-032 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready 0 throughout.
REQ-033 SHALL cover: store to 0x100 with addr_bits = 6 -> resp_error 1, subsequent load of 0x0 unchanged.
REQ-034 SHALL cover: reset_n low during WAIT of store to 0x20 -> outputs zero next edge, load 0x20 returns prior value.
REQ-035 SHALL cover: with DATA_MEM_ALIGN_CHECK_EN, load 0x13 -> resp_error 1, rdata 0; without it, load 0x13 returns word at 0x10.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response handshake with fixed wait states.
// Optional macro DATA_MEM_ALIGN_CHECK_EN also rejects requests whose byte address is not word aligned.
module data_mem_responder #(
  parameter int num_bits    = 32,
  parameter int addr_bits   = 6,
  parameter int wait_cycles = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [31:0]         req_addr,
  input  logic [num_bits-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [num_bits-1:0] resp_rdata,
  output logic                resp_error
);

  localparam int         depth     = 2 ** addr_bits;
  localparam bit         no_wait   = (wait_cycles == 0);
  localparam logic [3:0] wait_load = 4'(wait_cycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [addr_bits-1:0]   idx_q, idx_d;
  logic [num_bits-1:0]    wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [num_bits-1:0]    resp_rdata_q, resp_rdata_d;
  logic                   resp_error_q, resp_error_d;

  logic [num_bits-1:0]    mem_q [depth];

  logic                   accept;
  logic                   enter_resp;
  logic                   cur_write;
  logic [addr_bits-1:0]   cur_idx;
  logic [num_bits-1:0]    cur_wdata;
  logic                   cur_err;
  logic                   mem_we;

  // Out-of-range upper address bits, plus misalignment when the check is built in.
  function automatic logic addr_error(input logic [31:0] a);
    logic e;
    e = |(a >> (addr_bits + 2));
`ifdef DATA_MEM_ALIGN_CHECK_EN
    e = e | (a[1:0] != 2'b00);
`else
    e = e | 1'b0;
`endif
    return e;
  endfunction

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

  // With zero wait states the memory is touched on the accept edge itself,
  // so the live request fields must be used instead of the captured ones.
  assign accept    = (state_q == IDLE) && req_valid;
  assign cur_write = accept ? req_write                   : write_q;
  assign cur_idx   = accept ? req_addr[addr_bits+1:2]     : idx_q;
  assign cur_wdata = accept ? req_wdata                   : wdata_q;
  assign cur_err   = accept ? addr_error(req_addr)        : err_q;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    enter_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          idx_d   = req_addr[addr_bits+1:2];
          wdata_d = req_wdata;
          err_d   = addr_error(req_addr);
          if (no_wait) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_load;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // resp_valid rises one cycle after entering RESP and holds until taken.
        if (resp_valid_q && resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_error_d = 1'b0;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      resp_error_d = cur_err;
      resp_rdata_d = (cur_write || cur_err) ? '0 : mem_q[cur_idx];
    end
  end

  assign mem_we = enter_resp && cur_write && !cur_err;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // NOTE: the storage array has no reset; contents survive reset_n, and an
  // aborted store never reaches mem_we because reset pulls the FSM back to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      mem_q[cur_idx] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a wait_cycles=2 instance driven through a
// queue-checked monitor and a wait_cycles=0 instance checked directly for latency.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;

  logic        req_valid_0, req_ready_0, req_write_0;
  logic [31:0] req_addr_0, req_wdata_0;
  logic        resp_valid_0, resp_ready_0, resp_error_0;
  logic [31:0] resp_rdata_0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.num_bits(32), .addr_bits(6), .wait_cycles(2)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  data_mem_responder #(.num_bits(32), .addr_bits(6), .wait_cycles(0)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid_0),
    .req_ready  (req_ready_0),
    .req_write  (req_write_0),
    .req_addr   (req_addr_0),
    .req_wdata  (req_wdata_0),
    .resp_valid (resp_valid_0),
    .resp_ready (resp_ready_0),
    .resp_rdata (resp_rdata_0),
    .resp_error (resp_error_0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the rising edge of resp_valid, data on each handshake.
  always @(negedge clk) begin
    if (resp_valid === 1'b1 && prev_valid !== 1'b1) begin
      check("resp_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("latency", 32'(cyc - sb_q[0].acc), 32'd3);
    end
    if (resp_valid === 1'b1 && resp_ready === 1'b1 && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("rdata", resp_rdata, e.rdata);
      check("error", 32'(resp_error), 32'(e.err));
    end
    prev_valid = resp_valid;
  end

  // Issue one request; after accept, scramble the request fields and hold
  // req_valid for two WAIT cycles to show they are ignored.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", 32'(n >= 50), 32'd0);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    sb_q.push_back('{rdata: er, err: ee, acc: cyc});
    req_write = ~w; req_addr = a ^ 32'h4; req_wdata = ~d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    req_valid_0 = 1'b0; req_write_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0; resp_ready_0 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Store then load, range errors, top word, misaligned load.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0);
    issue(1'b1, 32'h100, 32'hBAD0BAD0, 32'h0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0);
    issue(1'b1, 32'hFC, 32'h0F0F0F0F, 32'h0, 1'b0);
    issue(1'b1, 32'h80000000, 32'h55555555, 32'h0, 1'b1);
    issue(1'b0, 32'hFC, 32'h0, 32'h0F0F0F0F, 1'b0);
    issue(1'b0, 32'h40000000, 32'h0, 32'h0, 1'b1);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    issue(1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
`else
    issue(1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);
`endif
    drain();

    // Backpressure: response held stable for five cycles.
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    n = 0;
    while (resp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("stall_valid_wait", 32'(n >= 10), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_rdata", resp_rdata, 32'hDEADBEEF);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drain();

    // Reset during WAIT of a store: store must not commit.
    issue(1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0);
    drain();
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'h0);
    check("abort_resp_error", 32'(resp_error), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 32'hAAAA5555, 1'b0);
    drain();

    // Zero-wait instance: resp_valid one edge after accept.
    req_valid_0 = 1'b1; req_write_0 = 1'b1; req_addr_0 = 32'h8; req_wdata_0 = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("w0_store_early", 32'(resp_valid_0), 32'd0);
    check("w0_store_ready_low", 32'(req_ready_0), 32'd0);
    @(negedge clk);
    check("w0_store_valid", 32'(resp_valid_0), 32'd1);
    check("w0_store_error", 32'(resp_error_0), 32'd0);
    @(posedge clk); #1;
    check("w0_ready_back", 32'(req_ready_0), 32'd1);
    req_valid_0 = 1'b1; req_write_0 = 1'b0; req_addr_0 = 32'h8;
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    @(negedge clk);
    check("w0_load_early", 32'(resp_valid_0), 32'd0);
    @(negedge clk);
    check("w0_load_valid", 32'(resp_valid_0), 32'd1);
    check("w0_load_rdata", resp_rdata_0, 32'hCAFEF00D);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
